// File: rtl/gate_exerciser.sv
// Sequential driver/checker for a 2-input, 1-output gate: sweeps {a,b} = 11,01,10,00,
// samples the gate output after a settle delay and reports per-vector errors plus pass/fail.
// Optional GATE_EXERCISER_LOG_EN adds a one-cycle log of every sampled vector and observation.
module gate_exerciser #(
   parameter int HOLD_CYCLES   = 12,
   parameter int SETTLE_CYCLES = 2,
   parameter int GATE_OP       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] err_vec
`ifdef GATE_EXERCISER_LOG_EN
   ,
   output logic       log_valid,
   output logic [1:0] log_vec,
   output logic       log_obs
`endif
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   if (SETTLE_CYCLES < 1 || HOLD_CYCLES <= SETTLE_CYCLES) begin : g_bad_timing
      $error("gate_exerciser: need SETTLE_CYCLES >= 1 and HOLD_CYCLES >= SETTLE_CYCLES+1");
   end
   if (GATE_OP < 0 || GATE_OP > 3) begin : g_bad_op
      $error("gate_exerciser: GATE_OP must be 0..3");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       k_q, k_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [2:0]       err_count_q, err_count_d;
   logic [3:0]       err_vec_q, err_vec_d;
`ifdef GATE_EXERCISER_LOG_EN
   logic             log_valid_q, log_valid_d;
   logic [1:0]       log_vec_q, log_vec_d;
   logic             log_obs_q, log_obs_d;
`endif

   logic       start_sweep;
   logic       sample_hit;
   logic       hold_end;
   logic       last_vec;
   logic       exp_bit;
   logic       mismatch;
   logic [1:0] next_ab;

   // Vector k as {a,b}: 11, 01, 10, 00.
   function automatic logic [1:0] vec_of(input logic [1:0] k);
      logic [1:0] v;
      case (k)
         2'd0:    v = 2'b11;
         2'd1:    v = 2'b01;
         2'd2:    v = 2'b10;
         default: v = 2'b00;
      endcase
      return v;
   endfunction

   function automatic logic gate_fn(input logic a, input logic b);
      logic y;
      case (GATE_OP)
         1:       y = a & b;
         2:       y = a ^ b;
         3:       y = ~(a & b);
         default: y = a | b;
      endcase
      return y;
   endfunction

   assign start_sweep = (state_q != S_RUN) && start;
   assign sample_hit  = (state_q == S_RUN) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
   assign hold_end    = (state_q == S_RUN) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));
   assign last_vec    = (k_q == 2'd3);
   assign exp_bit     = gate_fn(a_q, b_q);
   // Case inequality so an X/Z gate output is reported as a failure.
   assign mismatch    = (dut_c !== exp_bit);
   assign next_ab     = vec_of(k_q + 2'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (hold_end && last_vec) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      err_vec_d   = err_vec_q;
`ifdef GATE_EXERCISER_LOG_EN
      log_valid_d = sample_hit;
      log_vec_d   = log_vec_q;
      log_obs_d   = log_obs_q;
      if (sample_hit) begin
         log_vec_d = {a_q, b_q};
         log_obs_d = dut_c;
      end
`endif
      if (start_sweep) begin
         busy_d      = 1'b1;
         done_d      = 1'b0;
         pass_d      = 1'b0;
         err_count_d = 3'd0;
         err_vec_d   = 4'd0;
         k_d         = 2'd0;
         {a_d, b_d}  = vec_of(2'd0);
         cnt_d       = '0;
      end else if (state_q == S_RUN) begin
         cnt_d = cnt_q + 1'b1;
         if (sample_hit && mismatch) begin
            err_vec_d[k_q] = 1'b1;
            err_count_d    = err_count_q + 3'd1;
         end
         if (hold_end) begin
            cnt_d = '0;
            if (!last_vec) begin
               k_d        = k_q + 2'd1;
               {a_d, b_d} = next_ab;
            end else begin
               busy_d = 1'b0;
               done_d = 1'b1;
               a_d    = 1'b0;
               b_d    = 1'b0;
               pass_d = (err_vec_d == 4'd0);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_d_reset();
      end else begin
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         err_vec_q   <= err_vec_d;
`ifdef GATE_EXERCISER_LOG_EN
         log_valid_q <= log_valid_d;
         log_vec_q   <= log_vec_d;
         log_obs_q   <= log_obs_d;
`endif
      end
   end

   task automatic cnt_d_reset();
      cnt_q       <= '0;
      k_q         <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_vec_q   <= 4'd0;
`ifdef GATE_EXERCISER_LOG_EN
      log_valid_q <= 1'b0;
      log_vec_q   <= 2'd0;
      log_obs_q   <= 1'b0;
`endif
   endtask

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign err_vec   = err_vec_q;
`ifdef GATE_EXERCISER_LOG_EN
   assign log_valid = log_valid_q;
   assign log_vec   = log_vec_q;
   assign log_obs   = log_obs_q;
`endif

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a table of gate behaviours swept through the main instance,
// a second instance expecting AND while wired to an OR gate, plus reset/ignored-start sequences.
module tb_gate_exerciser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic [2:0] mode;

   logic       dut_a, dut_b, dut_c, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] err_vec;
`ifdef GATE_EXERCISER_LOG_EN
   logic       log_valid, log_obs;
   logic [1:0] log_vec;
`endif

   logic       and_a, and_b, and_c, and_busy, and_done, and_pass;
   logic [2:0] and_err_count;
   logic [3:0] and_err_vec;
`ifdef GATE_EXERCISER_LOG_EN
   logic       and_log_valid, and_log_obs;
   logic [1:0] and_log_vec;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   // Gate wired to the main instance: 0 OR, 1 tied 0, 2 tied 1, 3 XOR, 4 NOR.
   function automatic logic gate_model(input logic [2:0] m, input logic a, input logic b);
      logic y;
      case (m)
         3'd0:    y = a | b;
         3'd1:    y = 1'b0;
         3'd2:    y = 1'b1;
         3'd3:    y = a ^ b;
         default: y = ~(a | b);
      endcase
      return y;
   endfunction

   always_comb dut_c = gate_model(mode, dut_a, dut_b);
   assign and_c = and_a | and_b;

   gate_exerciser #(.HOLD_CYCLES(12), .SETTLE_CYCLES(2), .GATE_OP(0)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .err_vec(err_vec)
`ifdef GATE_EXERCISER_LOG_EN
      , .log_valid(log_valid), .log_vec(log_vec), .log_obs(log_obs)
`endif
   );

   gate_exerciser #(.HOLD_CYCLES(12), .SETTLE_CYCLES(2), .GATE_OP(1)) u_and (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(and_a), .dut_b(and_b), .dut_c(and_c),
      .busy(and_busy), .done(and_done), .pass(and_pass),
      .err_count(and_err_count), .err_vec(and_err_vec)
`ifdef GATE_EXERCISER_LOG_EN
      , .log_valid(and_log_valid), .log_vec(and_log_vec), .log_obs(and_log_obs)
`endif
   );

   typedef struct {
      logic [2:0] mode;
      logic [3:0] ev;
      logic [2:0] ec;
      logic       p;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ab"}, {dut_a, dut_b}, 2'b00);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_pass"}, pass, 1'b0);
      check({tag, "_err_count"}, err_count, 3'd0);
      check({tag, "_err_vec"}, err_vec, 4'd0);
`ifdef GATE_EXERCISER_LOG_EN
      check({tag, "_log"}, {log_valid, log_vec, log_obs}, 4'd0);
`endif
   endtask

   // Sweep with a scoreboard entry; pulse_at >= 1 re-asserts start for one cycle mid-sweep.
   task automatic run_sweep(input logic [7:0] exp_word, input int pulse_at);
      int k;
      int busy_n;
      logic [7:0] got;
      logic [7:0] want;
      logic [1:0] exp_ab [4];
      exp_ab[0] = 2'b11; exp_ab[1] = 2'b01; exp_ab[2] = 2'b10; exp_ab[3] = 2'b00;
      k = 0;
      busy_n = 0;
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(exp_word);
      forever begin
         @(negedge clk);
         start = 1'b0;
         k++;
         if (done) break;
         if (k > 200) begin
            check("sweep_timeout", k, 49);
            break;
         end
         if (busy) busy_n++;
         if (k == pulse_at) start = 1'b1;
         if (k == 1 || k == 13 || k == 25 || k == 37)
            check($sformatf("vec_%0d", (k - 1) / 12), {dut_a, dut_b}, exp_ab[(k - 1) / 12]);
`ifdef GATE_EXERCISER_LOG_EN
         check($sformatf("log_valid_k%0d", k), log_valid,
               (k == 3 || k == 15 || k == 27 || k == 39));
         if (log_valid && (k - 3) % 12 == 0) begin
            check("log_vec", log_vec, exp_ab[(k - 3) / 12]);
            check("log_obs", log_obs,
                  gate_model(mode, exp_ab[(k - 3) / 12][1], exp_ab[(k - 3) / 12][0]));
         end
`endif
      end
      start = 1'b0;
      check("done_edge", k - 1, 48);
      check("busy_cycles", busy_n, 48);
      check("busy_after", busy, 1'b0);
      check("ab_after", {dut_a, dut_b}, 2'b00);
      got = {pass, err_count, err_vec};
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         want = exp_q.pop_front();
         check("result", got, want);
      end
      check("and_result", {and_pass, and_err_count, and_err_vec}, {1'b0, 3'd2, 4'b0110});
      check("and_done", and_done, 1'b1);
   endtask

   initial begin
      tbl[0] = '{3'd0, 4'b0000, 3'd0, 1'b1};
      tbl[1] = '{3'd1, 4'b0111, 3'd3, 1'b0};
      tbl[2] = '{3'd2, 4'b1000, 3'd1, 1'b0};
      tbl[3] = '{3'd3, 4'b0001, 3'd1, 1'b0};
      tbl[4] = '{3'd4, 4'b1111, 3'd4, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      mode = 3'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].mode;
         run_sweep({tbl[i].p, tbl[i].ec, tbl[i].ev}, -1);
      end

      // Results hold in DONE.
      repeat (3) @(negedge clk);
      check("hold_done", done, 1'b1);
      check("hold_result", {pass, err_count, err_vec}, {1'b0, 3'd4, 4'b1111});

      // Reset 20 cycles into a sweep.
      mode = 3'd0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("mid_reset");
      run_sweep({1'b1, 3'd0, 4'b0000}, -1);

      // Start pulse while busy is ignored.
      mode = 3'd1;
      run_sweep({1'b0, 3'd3, 4'b0111}, 10);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
Self-contained sequential stimulus driver and response checker for any 2-input, 1-output combinational gate. It is the driving and checking end of the gate interface. On `start` it walks the four input vectors and holds each one for a fixed window. It samples the gate output after a settle delay, compares it against the expected function and reports per-vector errors plus an overall pass/fail. Used as a synthesizable bring-up checker next to the team's gate primitives.

Parameters:
- HOLD_CYCLES, 12, clock cycles each vector is driven; must be >= SETTLE_CYCLES+1.
- SETTLE_CYCLES, 2, cycles from vector applied to output sampled; must be >= 1.
- GATE_OP, 0, expected function: 0=OR, 1=AND, 2=XOR, 3=NAND.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- dut_a  output  1  gate input a.
- dut_b  output  1  gate input B.
- dut_c  input  1  gate output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until next start or reset.
- pass  output  1  valid when done=1; 1 means err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- err_vec  output  4  bit k set if vector k mismatched.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-sweep):
  - state=IDLE, vector index=0, counter=0.
  - All outputs 0: dut_a, dut_b, busy, done, pass, err_count, err_vec.
- Vector order, index k=0..3: {a,B} = 11, 01, 10, 00.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - state<=RUN, busy<=1, done<=0, pass<=0, err_count<=0, err_vec<=0.
  - k<=0, {dut_a,dut_b}<=vector 0, cnt<=0.
- RUN, each edge: cnt increments.
  - At cnt==SETTLE_CYCLES-1 (edge E0+k*HOLD_CYCLES+SETTLE_CYCLES), dut_c is compared against expected(vector k).
  - On mismatch: err_vec[k]<=1 and err_count<=err_count+1.
  - The comparison is case-inequality, so X/Z on dut_c counts as a mismatch.
  - At cnt==HOLD_CYCLES-1 with k<3: k<=k+1, next vector driven, cnt<=0. The next vector is therefore applied at edge E0+(k+1)*HOLD_CYCLES.
  - At cnt==HOLD_CYCLES-1 with k==3 (edge E0+4*HOLD_CYCLES): state<=DONE, busy<=0, done<=1, dut_a<=0, dut_b<=0.
  - pass<=1 iff no mismatch was recorded, including the vector-3 sample.
- DONE: outputs held stable. start=1 restarts exactly as from IDLE, clearing results in the same edge.
- start while busy: ignored; no restart and no effect on counters.
- Counter width: $clog2(HOLD_CYCLES+1).
- err_count saturation: not needed, since the maximum is 4.
- Parameter checks: illegal parameters (HOLD_CYCLES<=SETTLE_CYCLES or SETTLE_CYCLES<1) trigger an elaboration-time $error.

Optional Feature:
- Macro: GATE_EXERCISER_LOG_EN.
- When defined, three extra outputs are added:
  - log_valid (1): pulses high for exactly one cycle, the cycle after each sample edge.
  - log_vec (2): the {a,B} vector just sampled.
  - log_obs (1): the sampled dut_c value.
  - All three reset to 0.
- When not defined, these ports and their registers do not exist, and the remaining behaviour is identical.

Test Plan:
1. Correct OR gate on dut_c, default parameters, start pulsed at E0 -> done rises at edge E0+48; pass=1, err_count=0, err_vec=4'b0000; busy high for exactly 48 cycles.
2. dut_c tied to 0 -> vectors 11/01/10 expected 1, so err_vec=4'b0111, err_count=3, pass=0.
3. dut_c tied to 1 -> only vector 00 fails: err_vec=4'b1000, err_count=1, pass=0.
4. GATE_OP=1 (AND) with an OR gate connected -> vectors 01 and 10 fail: err_vec=4'b0110, err_count=2.
5. rst asserted 20 cycles into a sweep -> next edge: all outputs 0, state IDLE; a following start completes a clean sweep with pass=1; a start pulse at cycle 10 of a sweep is ignored and done still rises at E0+48.
6. With GATE_EXERCISER_LOG_EN defined, correct OR gate -> four single-cycle log_valid pulses at E0+3, E0+15, E0+27, E0+39, with (log_vec, log_obs) = (11,1), (01,1), (10,1), (00,0).
